// File: rtl/countdown_timer_pkg.sv
// Shared types, BCD limits and helpers for the MM:SS countdown timer.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam logic [3:0] BcdUnitsMax = 4'd9;
  localparam logic [3:0] BcdTensMax  = 4'd5;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // Force an arbitrary preset into a legal MM:SS BCD value.
  function automatic logic [15:0] sanitise(input logic [7:0] mm, input logic [7:0] ss);
    return {clamp_digit(mm[7:4], BcdUnitsMax), clamp_digit(mm[3:0], BcdUnitsMax),
            clamp_digit(ss[7:4], BcdTensMax), clamp_digit(ss[3:0], BcdUnitsMax)};
  endfunction

  // One-second BCD decrement with borrow; saturates at 00:00.
  function automatic logic [15:0] dec_mmss(input logic [15:0] v);
    logic [3:0] mt, mu, st, su;
    {mt, mu, st, su} = v;
    if (su != 4'd0) begin
      su = su - 4'd1;
    end else begin
      su = BcdUnitsMax;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = BcdTensMax;
        if (mu != 4'd0) begin
          mu = mu - 4'd1;
        end else begin
          mu = BcdUnitsMax;
          if (mt != 4'd0) begin
            mt = mt - 4'd1;
          end else begin
            {mt, mu, st, su} = 16'h0000;
          end
        end
      end
    end
    return {mt, mu, st, su};
  endfunction

endpackage

// File: rtl/countdown_timer_if.sv
// Control/status bundle between the countdown timer and its user.
interface countdown_timer_if;

  logic       tick_in;
  logic       start;
  logic       pause;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       done;
  logic       alarm;

  modport master (
    output tick_in, start, pause, load, preset_min, preset_sec,
    input  min_bcd, sec_bcd, running, done, alarm
  );

  modport slave (
    input  tick_in, start, pause, load, preset_min, preset_sec,
    output min_bcd, sec_bcd, running, done, alarm
  );

endinterface

// File: rtl/countdown_timer_tick_edge_sync.sv
// Brings the divider's slow square wave into the clk domain and emits a
// one-cycle pulse per rising edge. Reusable by any divider consumer.
module countdown_timer_tick_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_pulse
);

  logic sync1, sync2, sync3;

  // Two-flop synchroniser, edge register, and a registered pulse output.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      tick_pulse <= 1'b0;
    end else begin
      sync1      <= tick_in;
      sync2      <= sync1;
      sync3      <= sync2;
      tick_pulse <= sync2 & ~sync3;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer: prescales synchronised divider ticks to seconds
// and counts down under start/pause/load control, flagging 00:00.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 2
) (
  input logic             clk,
  input logic             rst,
  countdown_timer_if.slave bus
);

  localparam logic [7:0] SubMax = 8'(TICKS_PER_SEC - 1);

  state_e      state;
  logic [7:0]  min_q, sec_q, sub_cnt;
  logic        running_q, done_q, alarm_q;
  logic        tick_pulse, sec_evt, value_zero;
  logic [15:0] dec_val, preset_val;

  countdown_timer_tick_edge_sync u_tick_edge_sync (
    .clk        (clk),
    .rst        (rst),
    .tick_in    (bus.tick_in),
    .tick_pulse (tick_pulse)
  );

  assign sec_evt    = tick_pulse & (sub_cnt == SubMax);
  assign value_zero = ({min_q, sec_q} == 16'h0000);
  assign dec_val    = dec_mmss({min_q, sec_q});
  assign preset_val = sanitise(bus.preset_min, bus.preset_sec);

  // FSM, prescaler and BCD value; load overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= StIdle;
      min_q     <= 8'h00;
      sec_q     <= 8'h00;
      sub_cnt   <= 8'd0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      alarm_q <= 1'b0;
      if (bus.load) begin
        {min_q, sec_q} <= preset_val;
        sub_cnt        <= 8'd0;
        state          <= StIdle;
        running_q      <= 1'b0;
        done_q         <= 1'b0;
      end else begin
        unique case (state)
          StIdle, StPause: begin
            if (bus.start && !value_zero) begin
              state     <= StRun;
              running_q <= 1'b1;
            end
          end
          StRun: begin
            if (tick_pulse) begin
              sub_cnt <= sec_evt ? 8'd0 : sub_cnt + 8'd1;
            end
            if (sec_evt) begin
              {min_q, sec_q} <= dec_val;
            end
            // Reaching 00:00 beats a coincident pause: a paused 00:00 could never restart.
            if (sec_evt && (dec_val == 16'h0000)) begin
              state     <= StDone;
              running_q <= 1'b0;
              done_q    <= 1'b1;
              alarm_q   <= 1'b1;
            end else if (bus.pause) begin
              state     <= StPause;
              running_q <= 1'b0;
            end
          end
          StDone: begin
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.min_bcd = min_q;
  assign bus.sec_bcd = sec_q;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer with TICKS_PER_SEC = 2.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;

  countdown_timer_if bus ();

  countdown_timer #(
    .TICKS_PER_SEC (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_val(input string tag, input logic [15:0] exp);
    chk(tag, {bus.min_bcd, bus.sec_bcd}, exp);
  endtask

  // {running, done, alarm}
  task automatic chk_st(input string tag, input logic [2:0] exp);
    chk(tag, {13'd0, bus.running, bus.done, bus.alarm}, {13'd0, exp});
  endtask

  task automatic tick();
    bus.tick_in = 1'b1;
    repeat (4) step();
    bus.tick_in = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
    bus.preset_min = mm;
    bus.preset_sec = ss;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic do_pause();
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
  endtask

  initial begin
    bus.tick_in = 1'b0;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.load = 1'b0;
    bus.preset_min = 8'h00;
    bus.preset_sec = 8'h00;

    // Reset, then ticks while idle
    repeat (2) step();
    rst = 1'b0;
    chk_val("reset_value", 16'h0000);
    chk_st("reset_status", 3'b000);
    repeat (10) tick();
    chk_val("idle_ticks_value", 16'h0000);
    chk_st("idle_ticks_status", 3'b000);

    // Basic countdown 01:02
    do_load(8'h01, 8'h02);
    chk_val("load_0102", 16'h0102);
    chk_st("load_idle", 3'b000);
    do_start();
    chk_st("start_running", 3'b100);
    tick();
    chk_val("first_tick_no_change", 16'h0102);
    bus.tick_in = 1'b1;
    repeat (3) step();
    chk_val("latency_edge_n2", 16'h0102);
    step();
    chk_val("latency_edge_n3", 16'h0101);
    bus.tick_in = 1'b0;
    repeat (3) step();
    repeat (2) tick();
    chk_val("reach_0100", 16'h0100);
    repeat (2) tick();
    chk_val("minute_borrow_0059", 16'h0059);

    // Pause/resume at 00:30 with sub_cnt = 1
    do_load(8'h00, 8'h31);
    do_start();
    repeat (3) tick();
    chk_val("at_0030", 16'h0030);
    do_pause();
    chk_st("paused", 3'b000);
    repeat (5) tick();
    chk_val("paused_hold", 16'h0030);
    do_start();
    chk_st("resumed", 3'b100);
    tick();
    chk_val("resume_0029", 16'h0029);

    // Completion
    do_load(8'h00, 8'h01);
    do_start();
    tick();
    bus.tick_in = 1'b1;
    repeat (4) step();
    chk_val("done_value", 16'h0000);
    chk_st("done_entry", 3'b011);
    step();
    chk_st("alarm_one_cycle", 3'b010);
    bus.tick_in = 1'b0;
    repeat (2) step();
    do_start();
    repeat (2) tick();
    chk_val("done_sticky_value", 16'h0000);
    chk_st("done_sticky_status", 3'b010);
    do_load(8'h00, 8'h05);
    chk_val("reload_value", 16'h0005);
    chk_st("reload_clears_done", 3'b000);

    // Sanitisation and zero start
    do_load(8'hAF, 8'h7C);
    chk_val("sanitise", 16'h9959);
    do_load(8'h00, 8'h00);
    do_start();
    chk_st("zero_start_ignored", 3'b000);

    // load coincident with sec_evt
    do_load(8'h00, 8'h10);
    do_start();
    tick();
    bus.tick_in = 1'b1;
    repeat (3) step();
    bus.preset_min = 8'h00;
    bus.preset_sec = 8'h20;
    bus.load = 1'b1;
    step();
    bus.load = 1'b0;
    chk_val("load_beats_evt", 16'h0020);
    chk_st("load_beats_evt_idle", 3'b000);
    bus.tick_in = 1'b0;
    repeat (3) step();
    do_start();
    tick();
    chk_val("subcnt_cleared", 16'h0020);

    // pause coincident with sec_evt
    bus.tick_in = 1'b1;
    repeat (3) step();
    bus.pause = 1'b1;
    step();
    bus.pause = 1'b0;
    chk_val("pause_evt_dec", 16'h0019);
    chk_st("pause_evt_paused", 3'b000);
    bus.tick_in = 1'b0;
    repeat (3) step();

    // rst mid-countdown at 00:45
    do_load(8'h00, 8'h45);
    do_start();
    chk_st("run_0045", 3'b100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_val("rst_value", 16'h0000);
    chk_st("rst_status", 3'b000);
    do_start();
    chk_st("rst_no_preset", 3'b000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
